// File: rtl/seq_restoring_divider_if.sv
// =============================================================================
// seq_restoring_divider_if : start/busy/done handshake and operand/result bus
// Revision 1.0
// =============================================================================
`default_nettype none

interface seq_restoring_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// =============================================================================
// seq_restoring_divider : multi-cycle unsigned restoring divider, 1 bit/clock
// Revision 1.0
// =============================================================================
`default_nettype none

module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] qs;
  logic [WIDTH:0]   p;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dbz;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] qs_next;
  logic             no_borrow;
  logic             unused_p_msb;

  // A + ~B + 1 over WIDTH+1 bits; the carry-out doubles as the no-borrow flag.
  assign p_shift = {p[WIDTH-1:0], qs[WIDTH-1]};
  assign {no_borrow, diff} = {1'b0, p_shift} + {1'b0, ~{1'b0, d}}
                           + {{(WIDTH+1){1'b0}}, 1'b1};
  assign p_next  = no_borrow ? diff : p_shift;
  assign qs_next = {qs[WIDTH-2:0], no_borrow};

  // The partial remainder stays below the divisor, so its top bit never feeds back.
  assign unused_p_msb = p[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      d     <= '0;
      qs    <= '0;
      p     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.B != '0) begin
              d     <= bus.B;
              qs    <= bus.A;
              p     <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              q    <= '1;
              r    <= bus.A;
              dbz  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          p   <= p_next;
          qs  <= qs_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            q     <= qs_next;
            r     <= p_next[WIDTH-1:0];
            dbz   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.Q           = q;
  assign bus.R           = r;
  assign bus.div_by_zero = dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// =============================================================================
// tb_seq_restoring_divider : scenario tasks plus randomized reference-model run
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_seq_restoring_divider;
  localparam int W = 32;
  localparam int MAX_EDGES = 100;
  localparam int N_RANDOM = 1500;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Issue one request at the current point (just after a rising edge) and wait
  // for done. edges counts rising edges after the accepting one.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int edges, output int busy_cnt, output bit to);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    edges     = 0;
    busy_cnt  = 0;
    to        = 1'b0;
    while (bus.done !== 1'b1) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (edges >= MAX_EDGES) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/dbz=%b expected 000",
               {bus.busy, bus.done, bus.div_by_zero});
    end
    checks++;
    if (bus.Q !== '0) begin
      errors++;
      $display("FAIL reset_Q: got %h expected 0", bus.Q);
    end
    checks++;
    if (bus.R !== '0) begin
      errors++;
      $display("FAIL reset_R: got %h expected 0", bus.R);
    end
  endtask

  task automatic test_basic();
    int edges, bcnt;
    bit to;
    do_op(32'd100, 32'd7, edges, bcnt, to);
    checks++;
    if (to || edges != W) begin
      errors++;
      $display("FAIL basic_latency: done after %0d edges (timeout=%0b) expected %0d", edges, to, W);
    end
    checks++;
    if (bcnt != W) begin
      errors++;
      $display("FAIL basic_busy: busy high %0d cycles expected %0d", bcnt, W);
    end
    checks++;
    if (bus.Q !== 32'd14 || bus.R !== 32'd2 || bus.div_by_zero !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: Q=%0d R=%0d dbz=%b busy=%b expected Q=14 R=2 dbz=0 busy=0",
               bus.Q, bus.R, bus.div_by_zero, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.Q !== 32'd14 || bus.R !== 32'd2) begin
      errors++;
      $display("FAIL basic_hold: done=%b Q=%0d R=%0d expected done=0 Q=14 R=2",
               bus.done, bus.Q, bus.R);
    end
  endtask

  task automatic test_extremes();
    int edges, bcnt;
    bit to;
    do_op(32'hFFFF_FFFF, 32'd1, edges, bcnt, to);
    checks++;
    if (to || bus.Q !== 32'hFFFF_FFFF || bus.R !== 32'd0) begin
      errors++;
      $display("FAIL max_div_1: Q=%h R=%h expected Q=ffffffff R=0", bus.Q, bus.R);
    end
    @(posedge clk); #1;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, bcnt, to);
    checks++;
    if (to || bus.Q !== 32'd1 || bus.R !== 32'd0) begin
      errors++;
      $display("FAIL max_div_max: Q=%h R=%h expected Q=1 R=0", bus.Q, bus.R);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_small_and_zero();
    int edges, bcnt;
    bit to;
    do_op(32'd3, 32'd10, edges, bcnt, to);
    checks++;
    if (to || bus.Q !== 32'd0 || bus.R !== 32'd3 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL a_lt_b: Q=%0d R=%0d dbz=%b expected Q=0 R=3 dbz=0",
               bus.Q, bus.R, bus.div_by_zero);
    end
    @(posedge clk); #1;
    do_op(32'd5, 32'd0, edges, bcnt, to);
    checks++;
    if (to || edges != 0 || bcnt != 0) begin
      errors++;
      $display("FAIL dbz_timing: edges=%0d busy_cycles=%0d timeout=%0b expected 0 0 0",
               edges, bcnt, to);
    end
    checks++;
    if (bus.Q !== 32'hFFFF_FFFF || bus.R !== 32'd5 || bus.div_by_zero !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_result: Q=%h R=%0d dbz=%b busy=%b expected Q=ffffffff R=5 dbz=1 busy=0",
               bus.Q, bus.R, bus.div_by_zero, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_pulse: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int edges, bcnt;
    bit to;
    bus.start = 1'b1;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges = 0;
    repeat (5) begin
      @(posedge clk); #1;
      edges++;
    end
    bus.start = 1'b1;
    bus.A     = 32'd9;
    bus.B     = 32'd3;
    @(posedge clk); #1;
    edges++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && edges < MAX_EDGES) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges != W || bus.Q !== 32'd14 || bus.R !== 32'd2) begin
      errors++;
      $display("FAIL start_ignored: edges=%0d Q=%0d R=%0d expected edges=%0d Q=14 R=2",
               edges, bus.Q, bus.R, W);
    end
    // Issued in the done cycle, so the next done lands WIDTH+1 cycles later.
    do_op(32'd9, 32'd3, edges, bcnt, to);
    checks++;
    if (to || edges != W || bus.Q !== 32'd3 || bus.R !== 32'd0) begin
      errors++;
      $display("FAIL back_to_back: edges=%0d Q=%0d R=%0d expected edges=%0d Q=3 R=0",
               edges, bus.Q, bus.R, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int edges, bcnt;
    bit to;
    bit saw_done;
    bus.start = 1'b1;
    bus.A     = 32'd1000;
    bus.B     = 32'd33;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.Q !== '0 || bus.R !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b dbz=%b Q=%h R=%h expected all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.Q, bus.R);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL aborted_no_done: done/busy seen after abort=1 expected 0");
    end
    do_op(32'd1000, 32'd33, edges, bcnt, to);
    checks++;
    if (to || bus.Q !== 32'd30 || bus.R !== 32'd10) begin
      errors++;
      $display("FAIL after_reset: Q=%0d R=%0d expected Q=30 R=10", bus.Q, bus.R);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int edges, bcnt;
    bit to;
    logic [W-1:0] a, b, eq, er;
    logic ez;
    int mode;
    for (int i = 0; i < N_RANDOM; i++) begin
      a    = W'($urandom);
      mode = int'($urandom_range(0, 9));
      case (mode)
        0:       b = '0;
        1:       b = a;
        2:       begin a = W'($urandom_range(0, 1000)); b = a + W'($urandom_range(1, 5000)); end
        3:       b = W'($urandom_range(1, 255));
        4:       b = W'($urandom) >> $urandom_range(0, 31);
        default: b = W'($urandom);
      endcase
      if (b == '0 && mode != 0) b = 32'd1;
      ref_div(a, b, eq, er, ez);
      do_op(a, b, edges, bcnt, to);
      checks++;
      if (to || bus.Q !== eq || bus.R !== er || bus.div_by_zero !== ez) begin
        errors++;
        $display("FAIL random_%0d: A=%h B=%h got Q=%h R=%h dbz=%b expected Q=%h R=%h dbz=%b",
                 i, a, b, bus.Q, bus.R, bus.div_by_zero, eq, er, ez);
      end
      checks++;
      if (edges != (ez ? 0 : W)) begin
        errors++;
        $display("FAIL random_latency_%0d: edges=%0d expected %0d", i, edges, ez ? 0 : W);
      end
      if (!ez) begin
        checks++;
        if ((64'(bus.Q) * 64'(b) + 64'(bus.R)) !== 64'(a) || bus.R >= b) begin
          errors++;
          $display("FAIL random_invariant_%0d: A=%h B=%h Q=%h R=%h", i, a, b, bus.Q, bus.R);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_extremes();
    test_small_and_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
